pcie_byte_striper: RTL
======================

Name: pcie_byte_striper

Overview:
- Sits directly downstream of the PCIe symbol multiplexer and consumes its selected 8-bit symbol stream plus a K (control) flag.
- Data and non-COM symbols are striped round-robin across LANES lanes.
- An ordered set (a COM symbol followed by OS_LEN-1 further symbols) is replicated on every lane, one symbol per lane group.
- A partially filled lane group is closed with PAD symbols before an ordered set starts.

Parameters:
- LANES, 4, number of output lanes (power of 2, 2..8).
- OS_LEN, 4, total symbols in an ordered set, counting the COM (1..16).
- COM_SYM, 8'hBC, COM symbol code; recognised only when IN_K=1.
- PAD_SYM, 8'hF7, PAD symbol code inserted by the block (emitted with K=1).

Ports:
- CLK_2MHz  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- ENB  in  1  block enable; when low, no accept and no emit, all state held.
- IN_DATA  in  8  symbol from the multiplexer.
- IN_K  in  1  1 = control symbol.
- IN_VALID  in  1  IN_DATA/IN_K valid.
- IN_READY  out  1  combinational from state: ENB & (state != COM_EMIT).
- LANE_DATA  out  8*LANES  lane group; lane i = bits [8i+7:8i].
- LANE_K  out  LANES  per-lane K flag.
- LANE_VALID  out  1  one-cycle strobe marking a valid lane group.

Behaviour:
- Accept: IN_VALID & IN_READY sampled at a rising edge while reset=0.
- Reset (any cycle, including mid-group or mid-ordered-set):
  - LANE_DATA=0, LANE_K=0, LANE_VALID=0.
  - Lane pointer ptr=0, state=STRIPE, os_cnt=0; the group buffer is cleared and any partial group is discarded.
  - IN_READY follows its equation, so it is 1 if ENB=1.
- All outputs are registered. LANE_VALID is 0 in every cycle that does not emit.
- State STRIPE:
  - Accepting a non-COM symbol writes it into buffer slot ptr, then ptr++.
  - If ptr was LANES-1, the full group (including the new byte) is loaded into LANE_DATA/LANE_K at that same edge, LANE_VALID=1 for the following cycle, and ptr wraps to 0.
  - Latency: last byte accepted at edge N gives the group visible from edge N to edge N+1.
  - COM accepted with ptr==0: LANE_DATA = COM on all lanes, LANE_K = all 1, LANE_VALID=1, os_cnt=OS_LEN-1. Next state is OS if os_cnt>0, else STRIPE.
  - COM accepted with ptr!=0 (COM consumed): the group is emitted at that edge with slots ptr..LANES-1 = PAD_SYM, K=1; LANE_VALID=1; ptr=0; state=COM_EMIT.
- State COM_EMIT (IN_READY=0, exactly one cycle when ENB=1):
  - At the next edge, emit the COM broadcast (LANE_VALID=1), os_cnt=OS_LEN-1, then go to OS, or to STRIPE if OS_LEN=1.
- State OS:
  - Each accepted symbol is broadcast to all lanes with its IN_K, LANE_VALID=1, os_cnt--.
  - When os_cnt reaches 0, return to STRIPE with ptr=0.
  - A COM accepted in OS starts a new ordered set: broadcast it and reload os_cnt=OS_LEN-1.
- IN_VALID=0 or ENB=0: no change to ptr, buffer, os_cnt or state; LANE_VALID=0; LANE_DATA/LANE_K hold their last value.
- Non-COM K symbols (SKP, STP, SDP, END, EDB, FTS, IDL) stripe exactly like data, with LANE_K=1 in their slot.
- No back-pressure from downstream; the consumer must take every LANE_VALID strobe.

Test Plan:
- Reset, ENB=1, stream data 8'h11, 22, 33, 44 on consecutive cycles → one LANE_VALID pulse the cycle after 8'h44 is accepted, LANE_DATA=32'h44332211, LANE_K=4'b0000.
- Data 8'hFF, 8'hFF, then COM → group 32'hF7F7FFFF with LANE_K=4'b1100; IN_READY low for one cycle; then COM broadcast 32'hBCBCBCBC with K=4'b1111; next three symbols (K=1, 8'h1C each) broadcast as 32'h1C1C1C1C; the following data byte lands in lane 0.
- COM with ptr==0 followed by three symbols → four consecutive LANE_VALID pulses, no PAD inserted, IN_READY stays 1 throughout.
- Two data bytes, then ENB=0 for 5 cycles with IN_VALID=1, then ENB=1 and two more bytes → no strobe while ENB=0; a single group forms from all four bytes in order.
- reset asserted after 3 of 4 bytes (or mid-ordered-set) → LANE_VALID=0, outputs 0; the next 4 bytes form a fresh group starting in lane 0.
- Non-COM K symbol 8'hFB (K=1) striped in lane 2 → LANE_K=4'b0100 and no broadcast.

Source files
------------

// File: rtl/pcie_byte_striper.sv
// Round-robin byte striper for a PCIe link: data and non-COM symbols fill lane groups,
// ordered sets are broadcast on every lane, and a partial group is PAD-closed before a COM.
module pcie_byte_striper #(
    parameter int         LANES   = 4,
    parameter int         OS_LEN  = 4,
    parameter logic [7:0] COM_SYM = 8'hBC,
    parameter logic [7:0] PAD_SYM = 8'hF7
) (
    input  logic                 CLK_2MHz,
    input  logic                 reset,
    input  logic                 ENB,
    input  logic [7:0]           IN_DATA,
    input  logic                 IN_K,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [8*LANES-1:0]   LANE_DATA,
    output logic [LANES-1:0]     LANE_K,
    output logic                 LANE_VALID
);

    localparam int             PW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int             CW        = 5;
    localparam logic [CW-1:0]  OS_RELOAD = CW'(OS_LEN - 1);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(LANES - 1);
    localparam logic           OS_LONG   = (OS_LEN > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_STRIPE   = 2'd0,
        ST_COM_EMIT = 2'd1,
        ST_OS       = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        os_cnt_q, os_cnt_d;
    logic [8*LANES-1:0]   buf_data_q, buf_data_d;
    logic [LANES-1:0]     buf_k_q, buf_k_d;
    logic [8*LANES-1:0]   lane_data_q, lane_data_d;
    logic [LANES-1:0]     lane_k_q, lane_k_d;
    logic                 lane_valid_q, lane_valid_d;

    logic                 accept_s;
    logic                 is_com_s;
    logic [8*LANES-1:0]   fill_data_s, pad_data_s;
    logic [LANES-1:0]     fill_k_s, pad_k_s;

    assign IN_READY   = ENB & (state_q != ST_COM_EMIT);
    assign accept_s   = IN_VALID & IN_READY;
    assign is_com_s   = IN_K & (IN_DATA == COM_SYM);
    assign LANE_DATA  = lane_data_q;
    assign LANE_K     = lane_k_q;
    assign LANE_VALID = lane_valid_q;

    // Candidate groups: buffer plus the incoming byte, and buffer closed out with PADs from ptr up
    always_comb begin
        fill_data_s = buf_data_q;
        fill_k_s    = buf_k_q;
        pad_data_s  = buf_data_q;
        pad_k_s     = buf_k_q;
        fill_data_s[{ptr_q, 3'b000} +: 8] = IN_DATA;
        fill_k_s[ptr_q]                   = IN_K;
        for (int i = 0; i < LANES; i++) begin
            if (PW'(i) < ptr_q) begin
                pad_data_s[8*i +: 8] = buf_data_q[8*i +: 8];
                pad_k_s[i]           = buf_k_q[i];
            end else begin
                pad_data_s[8*i +: 8] = PAD_SYM;
                pad_k_s[i]           = 1'b1;
            end
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        os_cnt_d     = os_cnt_q;
        buf_data_d   = buf_data_q;
        buf_k_d      = buf_k_q;
        lane_data_d  = lane_data_q;
        lane_k_d     = lane_k_q;
        lane_valid_d = 1'b0;
        case (state_q)
            ST_STRIPE: begin
                if (accept_s) begin
                    if (is_com_s) begin
                        if (ptr_q == {PW{1'b0}}) begin
                            lane_data_d  = {LANES{COM_SYM}};
                            lane_k_d     = {LANES{1'b1}};
                            lane_valid_d = 1'b1;
                            os_cnt_d     = OS_RELOAD;
                            state_d      = OS_LONG ? ST_OS : ST_STRIPE;
                        end else begin
                            // The COM is consumed here; its broadcast goes out from COM_EMIT
                            lane_data_d  = pad_data_s;
                            lane_k_d     = pad_k_s;
                            lane_valid_d = 1'b1;
                            ptr_d        = {PW{1'b0}};
                            buf_data_d   = {(8*LANES){1'b0}};
                            buf_k_d      = {LANES{1'b0}};
                            state_d      = ST_COM_EMIT;
                        end
                    end else begin
                        if (ptr_q == PTR_LAST) begin
                            lane_data_d  = fill_data_s;
                            lane_k_d     = fill_k_s;
                            lane_valid_d = 1'b1;
                            ptr_d        = {PW{1'b0}};
                            buf_data_d   = {(8*LANES){1'b0}};
                            buf_k_d      = {LANES{1'b0}};
                        end else begin
                            buf_data_d = fill_data_s;
                            buf_k_d    = fill_k_s;
                            ptr_d      = ptr_q + PW'(1);
                        end
                    end
                end else begin
                    lane_valid_d = 1'b0;
                end
            end
            ST_COM_EMIT: begin
                if (ENB) begin
                    lane_data_d  = {LANES{COM_SYM}};
                    lane_k_d     = {LANES{1'b1}};
                    lane_valid_d = 1'b1;
                    os_cnt_d     = OS_RELOAD;
                    state_d      = OS_LONG ? ST_OS : ST_STRIPE;
                end else begin
                    lane_valid_d = 1'b0;
                end
            end
            ST_OS: begin
                if (accept_s) begin
                    lane_data_d  = {LANES{IN_DATA}};
                    lane_k_d     = {LANES{IN_K}};
                    lane_valid_d = 1'b1;
                    if (is_com_s) begin
                        os_cnt_d = OS_RELOAD;
                    end else begin
                        os_cnt_d = os_cnt_q - CW'(1);
                        if (os_cnt_q == CW'(1)) begin
                            state_d = ST_STRIPE;
                            ptr_d   = {PW{1'b0}};
                        end else begin
                            state_d = ST_OS;
                        end
                    end
                end else begin
                    lane_valid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_STRIPE;
                ptr_d    = {PW{1'b0}};
                os_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK_2MHz) begin
        if (reset) begin
            state_q      <= ST_STRIPE;
            ptr_q        <= {PW{1'b0}};
            os_cnt_q     <= {CW{1'b0}};
            buf_data_q   <= {(8*LANES){1'b0}};
            buf_k_q      <= {LANES{1'b0}};
            lane_data_q  <= {(8*LANES){1'b0}};
            lane_k_q     <= {LANES{1'b0}};
            lane_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            os_cnt_q     <= os_cnt_d;
            buf_data_q   <= buf_data_d;
            buf_k_q      <= buf_k_d;
            lane_data_q  <= lane_data_d;
            lane_k_q     <= lane_k_d;
            lane_valid_q <= lane_valid_d;
        end
    end

endmodule
